// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider.
package seq_div_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        DZ   = 2'd3
    } div_state_t;

    // Quotient reported when the divisor is zero.
    localparam logic [15:0] DZ_QUOTIENT = 16'hFFFF;

    // Two's-complement negate when n is set, pass-through otherwise.
    function automatic logic [15:0] neg_if(input logic n, input logic [15:0] v);
        return n ? 16'(16'd0 - v) : v;
    endfunction

endpackage

// File: rtl/seq_divider16_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained through
// group generate/propagate terms. Used by seq_divider16 as its trial
// subtraction engine.
module carry_lookahead_adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [8:0] cg;

    assign cg[0] = cin;
    assign cout  = cg[8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_grp
            logic [3:0] g;
            logic [3:0] p;
            logic [3:0] c;
            logic       grp_g;
            logic       grp_p;

            assign g = a[4*gi +: 4] & b[4*gi +: 4];
            assign p = a[4*gi +: 4] ^ b[4*gi +: 4];

            assign c[0] = cg[gi];
            assign c[1] = g[0] | (p[0] & c[0]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);

            assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                         | (p[3] & p[2] & p[1] & g[0]);
            assign grp_p = &p;

            assign cg[gi+1]      = grp_g | (grp_p & cg[gi]);
            assign sum[4*gi +: 4] = p ^ c;
        end
    endgenerate

endmodule

// File: rtl/seq_divider16.sv
// Sequential radix-2 restoring divider, 16-bit unsigned, one quotient bit
// per cycle. Trial subtraction runs through carry_lookahead_adder32.
// Optional macro SIGNED_DIV_EN adds an is_signed input for truncating
// signed division (sign fix-up folded into the final iteration, so the
// latency is the same as the unsigned case).
module seq_divider16
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [31:0]      neg_div_q, neg_div_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dz_q, dz_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic [31:0]      t_val;
    logic [31:0]      s_val;
    logic             adder_cout;
    logic             sub_ok;
    logic [WIDTH:0]   r_iter;
    logic [WIDTH-1:0] q_iter;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             unused_bits;

    // Shift the next dividend bit into the partial remainder and try subtracting.
    assign t_val = {{(32-WIDTH-1){1'b0}}, r_q[WIDTH-1:0], q_q[WIDTH-1]};

    carry_lookahead_adder32 u_trial_sub (
        .a    (t_val),
        .b    (neg_div_q),
        .cin  (1'b0),
        .sum  (s_val),
        .cout (adder_cout)
    );

    // Results are exact, so R stays below the divisor: the carry-out, the
    // sum bits above the remainder and R's top bit carry no information.
    assign unused_bits = ^{adder_cout, s_val[30:WIDTH+1], r_q[WIDTH]};

    assign sub_ok = ~s_val[31];
    assign r_iter = sub_ok ? s_val[WIDTH:0] : t_val[WIDTH:0];
    assign q_iter = {q_q[WIDTH-2:0], sub_ok};

    // Operand signs and magnitudes presented to the unsigned core.
    always_comb begin
`ifdef SIGNED_DIV_EN
        dvd_neg = is_signed & dividend[WIDTH-1];
        dvs_neg = is_signed & divisor[WIDTH-1];
`else
        dvd_neg = 1'b0;
        dvs_neg = 1'b0;
`endif
        dvd_mag = neg_if(dvd_neg, dividend);
        dvs_mag = neg_if(dvs_neg, divisor);
    end

    // Next-state and datapath update for the control FSM.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        r_d         = r_q;
        neg_div_d   = neg_div_q;
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d     = DZ;
                        done_d      = 1'b1;
                        quotient_d  = DZ_QUOTIENT;
                        remainder_d = dividend;
                        dz_d        = 1'b1;
                    end else begin
                        state_d   = CALC;
                        busy_d    = 1'b1;
                        q_d       = dvd_mag;
                        r_d       = '0;
                        neg_div_d = 32'd0 - {{(32-WIDTH){1'b0}}, dvs_mag};
                        count_d   = CNT_W'(WIDTH);
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
                    end
                end
            end
            CALC: begin
                r_d     = r_iter;
                q_d     = q_iter;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    quotient_d  = neg_if(neg_quo_q, q_iter);
                    remainder_d = neg_if(neg_rem_q, r_iter[WIDTH-1:0]);
                    dz_d        = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            DZ:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            neg_div_q   <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            neg_div_q   <= neg_div_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;

endmodule
